// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parametrised 2-read / 1-write register file used as operand storage for the
// ALU datapath. Reads are combinational; writes and clearing happen on the
// rising edge of clock. A hardware clear engine zeroes every entry, one per
// cycle, after reset or on request.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - a read port whose address matches an accepted write in the
//               same cycle returns data_in (write-through forwarding).
//   undefined - a read port returns the stored contents; a write becomes
//               visible on the cycle after its edge.
//
// Parameters:
//   WORD_SIZE   data width in bits
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH entries
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous active-high; starts a full clear sequence
//   clear_start  requests a clear sequence (ignored while busy)
//   write_enable write data_in to address3 (dropped while busy)
//   address1/2   read port addresses
//   address3     write address
//   data_in      write data
//   data_out1/2  read data, forced to 0 while busy
//   busy         registered; high while the clear engine runs
//   write_error  registered one-cycle pulse; a write was dropped
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_start,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [ADDR_WIDTH-1:0] address2,
    input  logic [ADDR_WIDTH-1:0] address3,
    input  logic [WORD_SIZE-1:0]  data_in,
    output logic [WORD_SIZE-1:0]  data_out1,
    output logic [WORD_SIZE-1:0]  data_out2,
    output logic                  busy,
    output logic                  write_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clr_ptr_reg;
    logic                    busy_reg;
    logic                    write_error_reg;
    logic [WORD_SIZE-1:0]    registers [DEPTH];

    // Clear engine and status outputs. busy_reg always equals (state == CLEAR);
    // it is kept as its own register so the output comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= CLEAR;
            clr_ptr_reg     <= '0;
            busy_reg        <= 1'b1;
            write_error_reg <= 1'b0;
        end else begin
            write_error_reg <= write_enable && busy_reg;
            case (state_reg)
                IDLE: begin
                    if (clear_start) begin
                        state_reg   <= CLEAR;
                        clr_ptr_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Increment wraps to 0 naturally after the last entry.
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == LAST_PTR) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: a single write port shared by the clear engine and user writes.
    // They never collide: user writes are only accepted while idle. Nothing is
    // written on a reset edge, so the array carries no reset of its own.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_reg == CLEAR) begin
                registers[clr_ptr_reg] <= '0;
            end else if (write_enable) begin
                registers[address3] <= data_in;
            end
        end
    end

    // Read ports, built identically for both addresses.
    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0][WORD_SIZE-1:0]  rd_data;

    assign rd_addr = {address2, address1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
`ifdef REGFILE_BYPASS_EN
            // Forward an accepted same-cycle write to a matching read port.
            assign rd_data[gi] = busy_reg ? '0 :
                                 (write_enable && (address3 == rd_addr[gi])) ? data_in :
                                 registers[rd_addr[gi]];
`else
            assign rd_data[gi] = busy_reg ? '0 : registers[rd_addr[gi]];
`endif
        end
    endgenerate

    assign data_out1   = rd_data[0];
    assign data_out2   = rd_data[1];
    assign busy        = busy_reg;
    assign write_error = write_error_reg;

endmodule
